// File: rtl/featuremap_accumulator_pkg.sv
// Shared types and fp32 constants for the feature-map accumulator layer.
package featuremap_accumulator_pkg;

   localparam int unsigned FP_WIDTH    = 32;
   localparam int unsigned FP_MAN_W    = 23;
   localparam int unsigned FP_SIGN_BIT = 31;
   localparam int unsigned FP_EXP_MSB  = 30;
   localparam int unsigned FP_EXP_LSB  = 23;

   localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
   localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_NEG_ZERO  = 32'h8000_0000;

   // Leaky ReLU slope of 0.125 is an exponent decrement of this amount.
   localparam logic [7:0] LEAKY_SHIFT = 8'd3;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAccum = 2'd1,
      StAct   = 2'd2
   } state_t;

   function automatic logic fp_is_nan(input logic [31:0] v);
      return (v[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_MAX) && (v[FP_MAN_W-1:0] != '0);
   endfunction

   function automatic logic fp_is_inf(input logic [31:0] v);
      return (v[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_MAX) && (v[FP_MAN_W-1:0] == '0);
   endfunction

endpackage

// File: rtl/FP32_Adder.sv
// Combinational fp32 adder: round-to-nearest-even, flush-to-zero on subnormals,
// saturation to infinity on overflow and canonical NaN propagation.
module FP32_Adder
   import featuremap_accumulator_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   logic              sa, sb, a_zero, b_zero;
   logic [7:0]        ea, eb;
   logic [22:0]       fa, fb;
   logic              swap;
   logic              s_big, s_small;
   logic [7:0]        e_big, e_small, e_diff;
   logic [22:0]       f_big, f_small;
   logic [26:0]       m_big, m_small, m_shift, lost_mask, m_norm;
   logic              sticky, eff_sub, round_up, lz_found;
   logic [27:0]       m_sum;
   logic [4:0]        lz;
   logic signed [9:0] e_norm, e_final;
   logic [24:0]       m_round;
   logic [22:0]       man_final;

   always_comb begin
      sa     = a[FP_SIGN_BIT];
      ea     = a[FP_EXP_MSB:FP_EXP_LSB];
      fa     = a[FP_MAN_W-1:0];
      sb     = b[FP_SIGN_BIT];
      eb     = b[FP_EXP_MSB:FP_EXP_LSB];
      fb     = b[FP_MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);

      // Order operands by magnitude so the subtraction never goes negative.
      swap    = {eb, fb} > {ea, fa};
      s_big   = swap ? sb : sa;
      e_big   = swap ? eb : ea;
      f_big   = swap ? fb : fa;
      s_small = swap ? sa : sb;
      e_small = swap ? ea : eb;
      f_small = swap ? fa : fb;
      e_diff  = e_big - e_small;

      // Three extra low bits carry guard, round and sticky.
      m_big     = {1'b1, f_big, 3'b000};
      m_small   = {1'b1, f_small, 3'b000};
      m_shift   = '0;
      lost_mask = '0;
      sticky    = 1'b0;
      if (e_diff >= 8'd27) begin
         sticky = 1'b1;
      end else begin
         m_shift   = m_small >> e_diff;
         lost_mask = (27'd1 << e_diff) - 27'd1;
         sticky    = |(m_small & lost_mask);
      end
      m_shift[0] = m_shift[0] | sticky;

      eff_sub = s_big ^ s_small;
      if (eff_sub) m_sum = {1'b0, m_big} - {1'b0, m_shift};
      else         m_sum = {1'b0, m_big} + {1'b0, m_shift};

      lz       = '0;
      lz_found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!lz_found) begin
            if (m_sum[i]) lz_found = 1'b1;
            else          lz = lz + 5'd1;
         end
      end

      if (m_sum[27]) begin
         m_norm = {m_sum[27:2], m_sum[1] | m_sum[0]};
         e_norm = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
         m_norm = m_sum[26:0] << lz;
         e_norm = $signed({2'b00, e_big}) - $signed({5'd0, lz});
      end

      round_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
      m_round  = {1'b0, m_norm[26:3]} + {24'd0, round_up};
      if (m_round[24]) begin
         e_final   = e_norm + 10'sd1;
         man_final = m_round[23:1];
      end else begin
         e_final   = e_norm;
         man_final = m_round[22:0];
      end

      if (fp_is_nan(a) || fp_is_nan(b)) begin
         sum = FP_CANON_NAN;
      end else if (fp_is_inf(a) && fp_is_inf(b)) begin
         sum = (sa != sb) ? FP_CANON_NAN : {sa, FP_EXP_MAX, 23'd0};
      end else if (fp_is_inf(a)) begin
         sum = {sa, FP_EXP_MAX, 23'd0};
      end else if (fp_is_inf(b)) begin
         sum = {sb, FP_EXP_MAX, 23'd0};
      end else if (a_zero && b_zero) begin
         sum = {sa & sb, 31'd0};
      end else if (a_zero) begin
         sum = {sb, eb, fb};
      end else if (b_zero) begin
         sum = {sa, ea, fa};
      end else if (m_sum == '0) begin
         sum = 32'd0;
      end else if (e_final <= 10'sd0) begin
         sum = {s_big, 31'd0};
      end else if (e_final >= 10'sd255) begin
         sum = {s_big, FP_EXP_MAX, 23'd0};
      end else begin
         sum = {s_big, e_final[7:0], man_final};
      end
   end

endmodule

// File: rtl/featuremap_accumulator.sv
// Sums NUM_CH per-channel fp32 partial results plus a bias, one channel per cycle,
// then applies an optional leaky ReLU and emits a single-cycle result strobe.
module featuremap_accumulator
   import featuremap_accumulator_pkg::*;
#(
   parameter int unsigned     DATA_WIDTH = 32,
   parameter int unsigned     NUM_CH     = 32,
   parameter logic [DATA_WIDTH-1:0] BIAS = 32'h0000_0000,
   parameter bit              LEAKY_EN   = 1'b1
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic                         valid_in,
   output logic                         ready_in,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         valid_out
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   state_t                                state_q, state_d;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]     ch_q;
   logic [IDX_W-1:0]                      idx_q;
   logic [DATA_WIDTH-1:0]                 acc_q, data_out_q;
   logic                                  valid_out_q;
   logic                                  accept;
   logic [DATA_WIDTH-1:0]                 ch_sel, sum, act_value;
   logic [7:0]                            act_exp;

   assign accept = valid_in && ready_in;
   assign ch_sel = ch_q[idx_q];

   FP32_Adder u_adder (
      .a   (acc_q),
      .b   (ch_sel),
      .sum (sum)
   );

   always_comb begin
      state_d  = state_q;
      ready_in = (state_q == StIdle);
      unique case (state_q)
         StIdle:  if (valid_in) state_d = StAccum;
         StAccum: if (idx_q == LAST_IDX) state_d = StAct;
         StAct:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      act_exp   = acc_q[FP_EXP_MSB:FP_EXP_LSB];
      act_value = acc_q;
      if (LEAKY_EN && acc_q[FP_SIGN_BIT]) begin
         if (act_exp <= LEAKY_SHIFT) act_value = FP_NEG_ZERO;
         else act_value = {1'b1, act_exp - LEAKY_SHIFT, acc_q[FP_MAN_W-1:0]};
      end
   end

   // Channel words need no reset: they are only read after an accept loads them.
   always_ff @(posedge Clk) begin
      if (!Rst && accept) ch_q <= data_in;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         acc_q       <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_out_q <= (state_q == StAct);
         if (accept) begin
            acc_q <= BIAS;
            idx_q <= '0;
         end else if (state_q == StAccum) begin
            acc_q <= sum;
            if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
         end
         if (state_q == StAct) data_out_q <= act_value;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_featuremap_accumulator.sv
// Randomised and directed checks of featuremap_accumulator against an exact-arithmetic fp32 model.
module tb_featuremap_accumulator;

   localparam int NCH = 32;
   localparam int DW  = 32;

   logic              Clk, Rst, valid_in;
   logic [NCH*DW-1:0] data_in;
   logic              ready_in, ready_nl, ready_b;
   logic [31:0]       dout, dout_nl, dout_b;
   logic              vout, vout_nl, vout_b;

   int vectors = 0;
   int miscompares = 0;

   featuremap_accumulator #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BIAS(32'h0), .LEAKY_EN(1'b1)) dut (
      .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
      .ready_in(ready_in), .data_out(dout), .valid_out(vout)
   );
   featuremap_accumulator #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BIAS(32'h0), .LEAKY_EN(1'b0)) dut_nl (
      .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
      .ready_in(ready_nl), .data_out(dout_nl), .valid_out(vout_nl)
   );
   featuremap_accumulator #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BIAS(32'h3F00_0000), .LEAKY_EN(1'b1))
      dut_b (
      .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
      .ready_in(ready_b), .data_out(dout_b), .valid_out(vout_b)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Exact sum in fixed point (unit 2^-150), then a single RNE rounding to fp32.
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      logic [299:0] ma, mb, mag, kept, rem, half;
      logic         sr;
      int           ea, eb, p, sh;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
      if (ea == 255 && eb == 255) return (a[31] != b[31]) ? 32'h7FC0_0000 : {a[31], 31'h7F80_0000};
      if (ea == 255) return {a[31], 31'h7F80_0000};
      if (eb == 255) return {b[31], 31'h7F80_0000};
      ma = (ea == 0) ? '0 : (300'({1'b1, a[22:0]}) << ea);
      mb = (eb == 0) ? '0 : (300'({1'b1, b[22:0]}) << eb);
      if (ma == 0 && mb == 0) return {a[31] & b[31], 31'd0};
      if (a[31] == b[31]) begin
         mag = ma + mb; sr = a[31];
      end else if (ma >= mb) begin
         mag = ma - mb; sr = a[31];
      end else begin
         mag = mb - ma; sr = b[31];
      end
      if (mag == 0) return 32'd0;
      p = 0;
      for (int i = 299; i >= 0; i--) begin
         if (mag[i]) begin
            p = i;
            break;
         end
      end
      sh = p - 23;
      if (sh <= 0) return {sr, 31'd0};
      kept = mag >> sh;
      rem  = mag & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 300'd1;
      if (kept[24]) begin
         kept = kept >> 1;
         sh++;
      end
      if (sh >= 255) return {sr, 31'h7F80_0000};
      return {sr, 8'(sh), kept[22:0]};
   endfunction

   function automatic logic [31:0] ref_act(input logic [31:0] v, input bit leaky);
      if (!leaky || !v[31]) return v;
      if (v[30:23] <= 8'd3) return 32'h8000_0000;
      return {1'b1, v[30:23] - 8'd3, v[22:0]};
   endfunction

   function automatic logic [31:0] ref_pixel(input logic [NCH*DW-1:0] vec, input logic [31:0] bias,
                                             input bit leaky);
      logic [31:0] acc;
      acc = bias;
      for (int k = 0; k < NCH; k++) acc = ref_add(acc, vec[k*DW +: DW]);
      return ref_act(acc, leaky);
   endfunction

   function automatic logic [31:0] rand_word();
      logic [7:0] e;
      e = 8'(120 + $urandom_range(0, 14));
      if ($urandom_range(0, 15) == 0) e = 8'd0;
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   function automatic logic [NCH*DW-1:0] rand_vec();
      logic [NCH*DW-1:0] v;
      for (int k = 0; k < NCH; k++) v[k*DW +: DW] = rand_word();
      return v;
   endfunction

   function automatic logic [NCH*DW-1:0] fill_vec(input logic [31:0] w);
      return {NCH{w}};
   endfunction

   // Latency counts the accepting edge as edge 1.
   task automatic apply_pixel(input logic [NCH*DW-1:0] vec, input string tag);
      logic [31:0] e0, enl, eb;
      int          lat;
      bit          seen;
      e0  = ref_pixel(vec, 32'h0, 1'b1);
      enl = ref_pixel(vec, 32'h0, 1'b0);
      eb  = ref_pixel(vec, 32'h3F00_0000, 1'b1);
      check({tag, "_ready_idle"}, {31'd0, ready_in}, 32'd1);
      data_in  = vec;
      valid_in = 1'b1;
      @(posedge Clk); #1;
      valid_in = 1'b0;
      data_in  = rand_vec();
      check({tag, "_ready_busy"}, {31'd0, ready_in}, 32'd0);
      seen = 1'b0;
      lat  = 0;
      for (int n = 1; n <= 60 && !seen; n++) begin
         @(posedge Clk); #1;
         if (vout) begin
            seen = 1'b1;
            lat  = n + 1;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(NCH + 2));
      check({tag, "_data"}, dout, e0);
      check({tag, "_data_noleaky"}, dout_nl, enl);
      check({tag, "_data_bias"}, dout_b, eb);
      check({tag, "_valid_noleaky"}, {31'd0, vout_nl}, 32'd1);
      check({tag, "_valid_bias"}, {31'd0, vout_b}, 32'd1);
      @(posedge Clk); #1;
      check({tag, "_strobe_drop"}, {31'd0, vout}, 32'd0);
      check({tag, "_hold"}, dout, e0);
   endtask

   logic [31:0]       bp_q[$];
   logic [31:0]       exp_w;
   logic [NCH*DW-1:0] v;
   int                readies, lows, results;
   bit                seen, saw;

   initial begin
      Rst      = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      repeat (3) @(posedge Clk);
      #1;
      Rst = 1'b0;
      check("rst_ready", {31'd0, ready_in}, 32'd1);
      check("rst_valid", {31'd0, vout}, 32'd0);
      check("rst_data", dout, 32'd0);
      @(posedge Clk); #1;
      check("rst_ready_after", {31'd0, ready_in}, 32'd1);

      apply_pixel(fill_vec(32'h3F80_0000), "ones");
      check("ones_const", dout, 32'h4200_0000);

      apply_pixel(fill_vec(32'hBF80_0000), "negones");
      check("leaky_const", dout, 32'hC080_0000);
      check("noleaky_const", dout_nl, 32'hC200_0000);

      apply_pixel('0, "zeros");
      check("bias_only_const", dout_b, 32'h3F00_0000);

      v = rand_vec();
      v[5*DW +: DW] = 32'h7FC0_0000;
      apply_pixel(v, "nan");
      check("nan_const", dout, 32'h7FC0_0000);

      apply_pixel(fill_vec(32'h7F00_0000), "ovf");
      check("ovf_const", dout, 32'h7F80_0000);

      for (int r = 0; r < 8; r++) apply_pixel(rand_vec(), $sformatf("rand%0d", r));

      // valid_in held high with fresh data every cycle
      readies = 0;
      lows    = 0;
      results = 0;
      valid_in = 1'b1;
      for (int c = 0; c < 3 * (NCH + 2); c++) begin
         if (vout) begin
            results++;
            check("bp_spacing", 32'(c), 32'(results * (NCH + 2)));
            exp_w = (bp_q.size() > 0) ? bp_q.pop_front() : 32'hxxxx_xxxx;
            check("bp_data", dout, exp_w);
         end
         data_in = rand_vec();
         if (ready_in) begin
            readies++;
            bp_q.push_back(ref_pixel(data_in, 32'h0, 1'b1));
         end else begin
            lows++;
         end
         @(posedge Clk); #1;
      end
      valid_in = 1'b0;
      check("bp_ready_high", 32'(readies), 32'd3);
      check("bp_ready_low", 32'(lows), 32'(3 * (NCH + 1)));
      check("bp_results", 32'(results), 32'd2);
      seen = vout;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(posedge Clk); #1;
         seen = vout;
      end
      check("bp_last_seen", {31'd0, seen}, 32'd1);
      exp_w = (bp_q.size() > 0) ? bp_q.pop_front() : 32'hxxxx_xxxx;
      check("bp_last_data", dout, exp_w);
      @(posedge Clk); #1;

      // reset in the middle of accumulation
      data_in  = fill_vec(32'h3F80_0000);
      valid_in = 1'b1;
      @(posedge Clk); #1;
      valid_in = 1'b0;
      repeat (14) @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      check("midrst_ready", {31'd0, ready_in}, 32'd1);
      check("midrst_valid", {31'd0, vout}, 32'd0);
      check("midrst_data", dout, 32'd0);
      check("midrst_data_bias", dout_b, 32'd0);
      saw = 1'b0;
      repeat (40) begin
         @(posedge Clk); #1;
         saw = saw | vout;
      end
      check("midrst_no_result", {31'd0, saw}, 32'd0);

      // reset wins over a simultaneous accept
      data_in  = fill_vec(32'h3F80_0000);
      valid_in = 1'b1;
      Rst      = 1'b1;
      @(posedge Clk); #1;
      Rst      = 1'b0;
      valid_in = 1'b0;
      check("rstprio_ready", {31'd0, ready_in}, 32'd1);
      saw = 1'b0;
      repeat (40) begin
         @(posedge Clk); #1;
         saw = saw | vout;
      end
      check("rstprio_no_result", {31'd0, saw}, 32'd0);

      apply_pixel(fill_vec(32'h3F80_0000), "fresh");
      check("fresh_const", dout, 32'h4200_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/featuremap_accumulator.md
FEATUREMAP_ACCUMULATOR -- requirements
Module: featuremap_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the IEEE-754 single-precision word width.
REQ-002 SHALL have parameter NUM_CH, default 32, the number of per-channel Conv2D3x3 partial results per pixel.
REQ-003 SHALL have parameter BIAS, default 32'h00000000, the fp32 bias for this output feature map.
REQ-004 SHALL have parameter LEAKY_EN, default 1; 1 applies leaky ReLU, 0 passes the biased sum through unchanged.
REQ-005 SHALL have port Clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-006 SHALL have port Rst, input, 1 bit; synchronous, active-high reset.
REQ-007 SHALL have port data_in, input, NUM_CH*DATA_WIDTH bits; channel k occupies bits [32k+31:32k].
REQ-008 SHALL have port valid_in, input, 1 bit; data_in is valid.
REQ-009 SHALL have port ready_in, output, 1 bit; block can accept data_in.
REQ-010 SHALL have port data_out, output, DATA_WIDTH bits; activated fp32 pixel value.
REQ-011 SHALL have port valid_out, output, 1 bit; single-cycle strobe qualifying data_out.

Function
REQ-012 SHALL implement FSM states IDLE, ACCUM, ACT; IDLE->ACCUM on accept, ACCUM->ACT after channel NUM_CH-1 is added, ACT->IDLE unconditionally.
REQ-013 SHALL drive ready_in high only in IDLE, combinationally from the state register.
REQ-014 SHALL accept on a rising edge where valid_in && ready_in: latch all NUM_CH words, load acc with BIAS, clear index to 0.
REQ-015 SHALL ignore valid_in while ready_in is low; no buffered or dropped-word side effects.
REQ-016 SHALL in ACCUM perform acc <= acc + ch[index] once per cycle, index increments 0..NUM_CH-1, with no wrap beyond NUM_CH-1.
REQ-017 SHALL in ACT register data_out = f(acc) and assert valid_out for exactly one cycle.
REQ-018 SHALL apply leaky ReLU (LEAKY_EN=1) with slope 0.125: positive/zero passes; negative has exponent reduced by 3; result flushes to -0 (32'h80000000) when biased exponent <= 3.
REQ-019 SHALL yield latency of NUM_CH+2 edges from the accepting edge to valid_out high (34 at defaults); throughput one pixel per NUM_CH+2 cycles.
REQ-020 SHALL permit a new accept in the same cycle valid_out is high, since the FSM is back in IDLE.
REQ-021 SHALL perform fp32 addition with round-to-nearest-even, subnormal inputs and results flushed to signed zero, and overflow saturated to signed infinity.
REQ-022 SHALL propagate NaN as 32'h7FC00000 when either adder operand is NaN.
REQ-023 SHALL hold data_out stable between valid_out strobes.

Reset
REQ-024 SHALL on Rst force state IDLE, index 0, acc 0, data_out 32'h00000000, and valid_out 0; ready_in is then high the cycle after Rst deasserts.
REQ-025 SHALL abandon any in-progress accumulation when Rst asserts mid-ACCUM or in ACT, with no valid_out for that pixel.
REQ-026 SHALL give Rst priority over an accept in the same cycle.

Structure
REQ-027 SHALL take FSM state encoding, fp32 field widths/positions, canonical NaN constant, and leaky-shift constant (3) from the shared layer package.
REQ-028 SHALL instantiate one combinational sub-module FP32_Adder (a, b -> sum) implementing REQ-021/REQ-022; the multiplexer, FSM, and activation stay in this module.

Verification
REQ-029 SHALL cover sum: all 32 channels 32'h3F800000, BIAS 0 -> data_out 32'h42000000 (32.0), valid_out 34 cycles after accept.
REQ-030 SHALL cover leaky ReLU: all channels 32'hBF800000, BIAS 0, LEAKY_EN=1 -> data_out 32'hC0800000 (-4.0); with LEAKY_EN=0 -> 32'hC2000000.
REQ-031 SHALL cover bias only: all channels 0, BIAS 32'h3F000000 -> data_out 32'h3F000000.
REQ-032 SHALL cover backpressure: valid_in held high continuously with changing data -> exactly one result per 34 cycles, each matching data present at its accept edge, ready_in low 33 of 34 cycles.
REQ-033 SHALL cover reset mid-operation: Rst pulsed at cycle 15 of ACCUM -> no valid_out, data_out 0, then a fresh 1.0-vector accept yields 32'h42000000.
REQ-034 SHALL cover NaN/overflow: channel 5 = 32'h7FC00000 -> data_out 32'h7FC00000; all channels 32'h7F000000 -> 32'h7F800000.
